fmrv32im_axil_sysreg: RTL

AXI4-Lite slave peripheral on the core's 16-bit peripheral port (`IM_AXI_*`), downstream of `fmrv32im_core`. Holds the machine timer (`mtime`/`mtimecmp`), raises the timer interrupt into the core's `INTERRUPT` vector, and provides a `tohost` register that captures riscv-tests completion codes for the bench. One outstanding read and one outstanding write. The read and write paths are independent.

---
 rtl/fmrv32im_sysreg_pkg.sv | 55 +++++
 rtl/fmrv32im_mtimer.sv | 64 ++++++
 rtl/fmrv32im_axil_sysreg.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fmrv32im_sysreg_pkg.sv
// fmrv32im system register block: shared definitions.
// Offsets, bit indices, AXI responses and FSM states.
package fmrv32im_sysreg_pkg;

  localparam logic [4:0] REG_TOHOST   = 5'h00;
  localparam logic [4:0] REG_MTIME_LO = 5'h04;
  localparam logic [4:0] REG_MTIME_HI = 5'h08;
  localparam logic [4:0] REG_MTCMP_LO = 5'h0C;
  localparam logic [4:0] REG_MTCMP_HI = 5'h10;
  localparam logic [4:0] REG_CTRL     = 5'h14;
  localparam logic [4:0] REG_STATUS   = 5'h18;

  localparam int CTRL_TMR_EN = 0;
  localparam int CTRL_IRQ_EN = 1;
  localparam int STATUS_PEND = 0;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE,
    W_HAVE_A,
    W_HAVE_D,
    W_RESP
  } wstate_t;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } rstate_t;

  function automatic logic [31:0] bmerge(
    input logic [31:0] old_v,
    input logic [31:0] new_v,
    input logic [3:0]  strb
  );
    logic [31:0] v;
    v = old_v;
    for (int i = 0; i < 4; i++)
      if (strb[i]) v[8*i +: 8] = new_v[8*i +: 8];
    return v;
  endfunction

  function automatic logic reg_hit(input logic [4:0] off);
    logic hit;
    case (off)
      REG_TOHOST, REG_MTIME_LO, REG_MTIME_HI,
      REG_MTCMP_LO, REG_MTCMP_HI,
      REG_CTRL, REG_STATUS: hit = 1'b1;
      default:              hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/fmrv32im_mtimer.sv
// fmrv32im machine timer: 64-bit mtime, mtimecmp,
// byte-strobed loads and the sticky PEND flag.
module fmrv32im_mtimer
  import fmrv32im_sysreg_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_tmr_en,
  input  logic        i_we_lo,
  input  logic        i_we_hi,
  input  logic        i_we_cmplo,
  input  logic        i_we_cmphi,
  input  logic [31:0] i_wdata,
  input  logic [3:0]  i_wstrb,
  input  logic        i_clr,
  output logic [63:0] o_mtime,
  output logic [63:0] o_mtimecmp,
  output logic        o_pend
);

  logic [63:0] r_mtime;
  logic [63:0] r_cmp;
  logic        r_pend;

  // Counter: a bus load of either half beats the increment, no carry.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_mtime <= '0;
    end else if (i_we_lo) begin
      r_mtime[31:0] <= bmerge(r_mtime[31:0], i_wdata, i_wstrb);
    end else if (i_we_hi) begin
      r_mtime[63:32] <= bmerge(r_mtime[63:32], i_wdata, i_wstrb);
    end else if (i_tmr_en) begin
      r_mtime <= r_mtime + 64'd1;
    end
  end

  // Compare value, loaded bytewise from the bus.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cmp <= '0;
    end else if (i_we_cmplo) begin
      r_cmp[31:0] <= bmerge(r_cmp[31:0], i_wdata, i_wstrb);
    end else if (i_we_cmphi) begin
      r_cmp[63:32] <= bmerge(r_cmp[63:32], i_wdata, i_wstrb);
    end
  end

  // Pending flag: compare hit sets, W1C clears, set wins.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pend <= 1'b0;
    end else if (i_tmr_en && (r_mtime >= r_cmp)) begin
      r_pend <= 1'b1;
    end else if (i_clr) begin
      r_pend <= 1'b0;
    end
  end

  assign o_mtime    = r_mtime;
  assign o_mtimecmp = r_cmp;
  assign o_pend     = r_pend;

endmodule

// File: rtl/fmrv32im_axil_sysreg.sv
// fmrv32im AXI4-Lite system registers: tohost,
// machine timer access and the timer interrupt line.
module fmrv32im_axil_sysreg
  import fmrv32im_sysreg_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int IRQ_BIT = 7
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [ADDR_W-1:0] S_AXI_AWADDR,
  input  logic [3:0]        S_AXI_AWCACHE,
  input  logic [2:0]        S_AXI_AWPROT,
  input  logic              S_AXI_AWVALID,
  output logic              S_AXI_AWREADY,
  input  logic [31:0]       S_AXI_WDATA,
  input  logic [3:0]        S_AXI_WSTRB,
  input  logic              S_AXI_WVALID,
  output logic              S_AXI_WREADY,
  output logic [1:0]        S_AXI_BRESP,
  output logic              S_AXI_BVALID,
  input  logic              S_AXI_BREADY,
  input  logic [ADDR_W-1:0] S_AXI_ARADDR,
  input  logic [3:0]        S_AXI_ARCACHE,
  input  logic [2:0]        S_AXI_ARPROT,
  input  logic              S_AXI_ARVALID,
  output logic              S_AXI_ARREADY,
  output logic [31:0]       S_AXI_RDATA,
  output logic [1:0]        S_AXI_RRESP,
  output logic              S_AXI_RVALID,
  input  logic              S_AXI_RREADY,
  output logic [31:0]       INTERRUPT,
  output logic              TEST_DONE,
  output logic              TEST_PASS,
  output logic [31:0]       TEST_RESULT
);

  wstate_t r_wstate, w_wnext;
  rstate_t r_rstate, w_rnext;

  logic              r_live;
  logic [ADDR_W-1:0] r_awaddr;
  logic [31:0]       r_wdata;
  logic [3:0]        r_wstrb;
  logic [1:0]        r_bresp;
  logic [31:0]       r_rdata;
  logic [1:0]        r_rresp;
  logic [31:0]       r_tohost;
  logic [31:0]       r_result;
  logic              r_done;
  logic              r_pass;
  logic              r_tmr_en;
  logic              r_irq_en;
  logic              r_irq;

  logic              w_awready, w_wready, w_bvalid;
  logic              w_wr_fire, w_ar_fire;
  logic              w_arready, w_rvalid;
  logic [ADDR_W-1:0] w_waddr;
  logic [31:0]       w_wdata;
  logic [3:0]        w_wstrb;
  logic              w_whi, w_wmapped;
  logic [4:0]        w_woff;
  logic              w_rhi, w_rmapped;
  logic [4:0]        w_roff;
  logic [31:0]       w_rdata;
  logic [31:0]       w_tohost_nx;
  logic [63:0]       w_mtime, w_mtimecmp;
  logic              w_pend;
  logic              w_unused;

  assign w_unused = ^{S_AXI_AWCACHE, S_AXI_AWPROT,
                      S_AXI_ARCACHE, S_AXI_ARPROT};

  // Ready gate: keeps all READYs low on the first cycle out of reset.
  always_ff @(posedge CLK) begin
    if (RST) r_live <= 1'b0;
    else     r_live <= 1'b1;
  end

  // Write FSM state register.
  always_ff @(posedge CLK) begin
    if (RST) r_wstate <= W_IDLE;
    else     r_wstate <= w_wnext;
  end

  // Write FSM next state, handshake outputs and commit strobe.
  always_comb begin
    w_wnext   = r_wstate;
    w_awready = 1'b0;
    w_wready  = 1'b0;
    w_bvalid  = 1'b0;
    w_wr_fire = 1'b0;
    unique case (r_wstate)
      W_IDLE: begin
        w_awready = r_live;
        w_wready  = r_live;
        if (r_live && S_AXI_AWVALID && S_AXI_WVALID) begin
          w_wr_fire = 1'b1;
          w_wnext   = W_RESP;
        end else if (r_live && S_AXI_AWVALID) begin
          w_wnext = W_HAVE_A;
        end else if (r_live && S_AXI_WVALID) begin
          w_wnext = W_HAVE_D;
        end
      end
      W_HAVE_A: begin
        w_wready = 1'b1;
        if (S_AXI_WVALID) begin
          w_wr_fire = 1'b1;
          w_wnext   = W_RESP;
        end
      end
      W_HAVE_D: begin
        w_awready = 1'b1;
        if (S_AXI_AWVALID) begin
          w_wr_fire = 1'b1;
          w_wnext   = W_RESP;
        end
      end
      W_RESP: begin
        w_bvalid = 1'b1;
        if (S_AXI_BREADY) w_wnext = W_IDLE;
      end
    endcase
  end

  // Hold whichever half of the write arrived first.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_awaddr <= '0;
      r_wdata  <= '0;
      r_wstrb  <= '0;
    end else begin
      if (w_awready && S_AXI_AWVALID) r_awaddr <= S_AXI_AWADDR;
      if (w_wready && S_AXI_WVALID) begin
        r_wdata <= S_AXI_WDATA;
        r_wstrb <= S_AXI_WSTRB;
      end
    end
  end

  assign w_waddr = (r_wstate == W_HAVE_A) ? r_awaddr : S_AXI_AWADDR;
  assign w_wdata = (r_wstate == W_HAVE_D) ? r_wdata : S_AXI_WDATA;
  assign w_wstrb = (r_wstate == W_HAVE_D) ? r_wstrb : S_AXI_WSTRB;

  assign w_whi     = (w_waddr[ADDR_W-1:5] == '0);
  assign w_woff    = w_waddr[4:0];
  assign w_wmapped = w_whi && reg_hit(w_woff);

  assign w_tohost_nx = bmerge(r_tohost, w_wdata, w_wstrb);

  // Write response captured at the commit edge.
  always_ff @(posedge CLK) begin
    if (RST)            r_bresp <= RESP_OKAY;
    else if (w_wr_fire) r_bresp <= w_wmapped ? RESP_OKAY : RESP_SLVERR;
  end

  // tohost register and sticky test status.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_tohost <= '0;
      r_result <= '0;
      r_done   <= 1'b0;
      r_pass   <= 1'b0;
    end else if (w_wr_fire && w_whi && w_woff == REG_TOHOST) begin
      r_tohost <= w_tohost_nx;
      if (w_tohost_nx != '0) begin
        r_result <= w_tohost_nx;
        r_done   <= 1'b1;
        r_pass   <= (w_tohost_nx == 32'd1);
      end
    end
  end

  // Control bits live in byte 0 only.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_tmr_en <= 1'b0;
      r_irq_en <= 1'b0;
    end else if (w_wr_fire && w_whi && w_woff == REG_CTRL
                 && w_wstrb[0]) begin
      r_tmr_en <= w_wdata[CTRL_TMR_EN];
      r_irq_en <= w_wdata[CTRL_IRQ_EN];
    end
  end

  fmrv32im_mtimer u_mtimer (
    .i_clk      (CLK),
    .i_rst      (RST),
    .i_tmr_en   (r_tmr_en),
    .i_we_lo    (w_wr_fire && w_whi && w_woff == REG_MTIME_LO),
    .i_we_hi    (w_wr_fire && w_whi && w_woff == REG_MTIME_HI),
    .i_we_cmplo (w_wr_fire && w_whi && w_woff == REG_MTCMP_LO),
    .i_we_cmphi (w_wr_fire && w_whi && w_woff == REG_MTCMP_HI),
    .i_wdata    (w_wdata),
    .i_wstrb    (w_wstrb),
    .i_clr      (w_wr_fire && w_whi && w_woff == REG_STATUS
                 && w_wstrb[0] && w_wdata[STATUS_PEND]),
    .o_mtime    (w_mtime),
    .o_mtimecmp (w_mtimecmp),
    .o_pend     (w_pend)
  );

  // Registered interrupt line.
  always_ff @(posedge CLK) begin
    if (RST) r_irq <= 1'b0;
    else     r_irq <= w_pend && r_irq_en;
  end

  // Read FSM state register.
  always_ff @(posedge CLK) begin
    if (RST) r_rstate <= R_IDLE;
    else     r_rstate <= w_rnext;
  end

  // Read FSM next state and handshake outputs.
  always_comb begin
    w_rnext   = r_rstate;
    w_arready = 1'b0;
    w_rvalid  = 1'b0;
    w_ar_fire = 1'b0;
    unique case (r_rstate)
      R_IDLE: begin
        w_arready = r_live;
        if (r_live && S_AXI_ARVALID) begin
          w_ar_fire = 1'b1;
          w_rnext   = R_DATA;
        end
      end
      R_DATA: begin
        w_rvalid = 1'b1;
        if (S_AXI_RREADY) w_rnext = R_IDLE;
      end
    endcase
  end

  assign w_rhi     = (S_AXI_ARADDR[ADDR_W-1:5] == '0);
  assign w_roff    = S_AXI_ARADDR[4:0];
  assign w_rmapped = w_rhi && reg_hit(w_roff);

  // Read mux over current (pre-edge) register values.
  always_comb begin
    w_rdata = '0;
    case (w_roff)
      REG_TOHOST:   w_rdata = r_tohost;
      REG_MTIME_LO: w_rdata = w_mtime[31:0];
      REG_MTIME_HI: w_rdata = w_mtime[63:32];
      REG_MTCMP_LO: w_rdata = w_mtimecmp[31:0];
      REG_MTCMP_HI: w_rdata = w_mtimecmp[63:32];
      REG_CTRL:     w_rdata = {30'd0, r_irq_en, r_tmr_en};
      REG_STATUS:   w_rdata = {31'd0, w_pend};
      default:      w_rdata = '0;
    endcase
    if (!w_rhi) w_rdata = '0;
  end

  // Read data captured at the AR handshake edge.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_rdata <= '0;
      r_rresp <= RESP_OKAY;
    end else if (w_ar_fire) begin
      r_rdata <= w_rdata;
      r_rresp <= w_rmapped ? RESP_OKAY : RESP_SLVERR;
    end
  end

  assign S_AXI_AWREADY = w_awready;
  assign S_AXI_WREADY  = w_wready;
  assign S_AXI_BVALID  = w_bvalid;
  assign S_AXI_BRESP   = r_bresp;
  assign S_AXI_ARREADY = w_arready;
  assign S_AXI_RVALID  = w_rvalid;
  assign S_AXI_RDATA   = r_rdata;
  assign S_AXI_RRESP   = r_rresp;
  assign INTERRUPT     = 32'(r_irq) << IRQ_BIT;
  assign TEST_DONE     = r_done;
  assign TEST_PASS     = r_pass;
  assign TEST_RESULT   = r_result;

endmodule
